// File: rtl/vga_rect_plotter_if.sv
// Command and pixel-stream bundle between the VGA top level and the rectangle plotter.
// The top level (master) issues load/plot/clear requests and consumes the pixel stream.
interface vga_rect_plotter_if #(
    parameter int XW = 8,
    parameter int YW = 7,
    parameter int CW = 3,
    parameter int SW = 5
);
    logic [XW-1:0] iXY_Coord;
    logic          iLoadX;
    logic          iPlotBox;
    logic          iBlack;
    logic [CW-1:0] iColour;
    logic [SW-1:0] iWidth;
    logic [SW-1:0] iHeight;

    logic [XW-1:0] oX;
    logic [YW-1:0] oY;
    logic [CW-1:0] oColour;
    logic          oPlot;
    logic          oBusy;
    logic          oDone;

    modport master (
        output iXY_Coord, iLoadX, iPlotBox, iBlack, iColour, iWidth, iHeight,
        input  oX, oY, oColour, oPlot, oBusy, oDone
    );

    modport slave (
        input  iXY_Coord, iLoadX, iPlotBox, iBlack, iColour, iWidth, iHeight,
        output oX, oY, oColour, oPlot, oBusy, oDone
    );
endinterface

// File: rtl/vga_rect_plotter.sv
// Filled-rectangle / full-screen-clear pixel generator for the VGA adapter.
// Emits one pixel per clock in raster order (x fastest), clipping off-screen pixels.
module vga_rect_plotter #(
    parameter int X_SCREEN_PIXELS = 160,
    parameter int Y_SCREEN_PIXELS = 120,
    parameter int XW              = 8,
    parameter int YW              = 7,
    parameter int CW              = 3,
    parameter int SW              = 5
) (
    input logic               clk,
    input logic               resetn,
    vga_rect_plotter_if.slave bus
);

    // Size registers must hold either a user size or a full screen dimension.
    localparam int XDIM_W = $clog2(X_SCREEN_PIXELS + 1);
    localparam int YDIM_W = $clog2(Y_SCREEN_PIXELS + 1);
    localparam int WW     = (SW > XDIM_W) ? SW : XDIM_W;
    localparam int HW     = (SW > YDIM_W) ? SW : YDIM_W;
    localparam int XSW    = XW + 1;
    localparam int YSW    = YW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRAW  = 2'd1;
    localparam logic [1:0] S_CLEAR = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state;
    logic [XW-1:0] x_reg;
    logic [YW-1:0] y_reg;
    logic [CW-1:0] col_reg;
    logic [WW-1:0] w_reg;
    logic [HW-1:0] h_reg;
    logic [WW-1:0] xc;
    logic [HW-1:0] yc;

    logic load_x_q;
    logic plot_q;
    logic black_q;

    logic load_x_edge;
    logic plot_edge;
    logic black_edge;
    logic scanning;
    logic last_col;
    logic last_row;

    logic [XSW-1:0] x_full;
    logic [YSW-1:0] y_full;

    function automatic logic [XSW-1:0] x_sum(input logic [XW-1:0] base,
                                             input logic [WW-1:0] ofs);
        return {1'b0, base} + XSW'(ofs);
    endfunction

    function automatic logic [YSW-1:0] y_sum(input logic [YW-1:0] base,
                                             input logic [HW-1:0] ofs);
        return {1'b0, base} + YSW'(ofs);
    endfunction

    function automatic logic on_screen(input logic [XSW-1:0] xs,
                                       input logic [YSW-1:0] ys);
        return (xs < XSW'(X_SCREEN_PIXELS)) && (ys < YSW'(Y_SCREEN_PIXELS));
    endfunction

    assign load_x_edge = bus.iLoadX   & ~load_x_q;
    assign plot_edge   = bus.iPlotBox & ~plot_q;
    assign black_edge  = bus.iBlack   & ~black_q;

    assign scanning = (state == S_DRAW) || (state == S_CLEAR);
    assign last_col = (xc == w_reg - WW'(1));
    assign last_row = (yc == h_reg - HW'(1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= S_IDLE;
            x_reg    <= '0;
            y_reg    <= '0;
            col_reg  <= '0;
            w_reg    <= '0;
            h_reg    <= '0;
            xc       <= '0;
            yc       <= '0;
            load_x_q <= 1'b0;
            plot_q   <= 1'b0;
            black_q  <= 1'b0;
        end else begin
            // Edge history follows the inputs in every state so held levels never retrigger.
            load_x_q <= bus.iLoadX;
            plot_q   <= bus.iPlotBox;
            black_q  <= bus.iBlack;

            case (state)
                S_IDLE: begin
                    if (black_edge) begin
                        x_reg   <= '0;
                        y_reg   <= '0;
                        col_reg <= '0;
                        w_reg   <= WW'(X_SCREEN_PIXELS);
                        h_reg   <= HW'(Y_SCREEN_PIXELS);
                        xc      <= '0;
                        yc      <= '0;
                        state   <= S_CLEAR;
                    end else if (plot_edge) begin
                        y_reg   <= bus.iXY_Coord[YW-1:0];
                        col_reg <= bus.iColour;
                        w_reg   <= WW'(bus.iWidth);
                        h_reg   <= HW'(bus.iHeight);
                        xc      <= '0;
                        yc      <= '0;
                        if ((bus.iWidth == '0) || (bus.iHeight == '0))
                            state <= S_DONE;
                        else
                            state <= S_DRAW;
                    end else if (load_x_edge) begin
                        x_reg <= bus.iXY_Coord;
                    end
                end

                S_DRAW, S_CLEAR: begin
                    if (last_col) begin
                        xc <= '0;
                        if (last_row) begin
                            yc    <= '0;
                            state <= S_DONE;
                        end else begin
                            yc <= yc + HW'(1);
                        end
                    end else begin
                        xc <= xc + WW'(1);
                    end
                end

                S_DONE: state <= S_IDLE;

                default: state <= S_IDLE;
            endcase
        end
    end

    assign x_full = x_sum(x_reg, xc);
    assign y_full = y_sum(y_reg, yc);

    assign bus.oX      = x_full[XW-1:0];
    assign bus.oY      = y_full[YW-1:0];
    assign bus.oColour = col_reg;
    assign bus.oBusy   = scanning;
    assign bus.oPlot   = scanning && on_screen(x_full, y_full);
    assign bus.oDone   = (state == S_DONE);

endmodule

// File: tb/tb_vga_rect_plotter.sv
// Directed self-checking bench for vga_rect_plotter: draw, clip, clear, zero size,
// edge priority / no-retrigger, and mid-draw reset.
module tb_vga_rect_plotter;

    localparam int XS = 160;
    localparam int YS = 120;
    localparam int XW = 8;
    localparam int YW = 7;
    localparam int CW = 3;
    localparam int SW = 5;

    logic clk;
    logic resetn;
    int   total;
    int   bad;

    vga_rect_plotter_if #(.XW(XW), .YW(YW), .CW(CW), .SW(SW)) bus ();

    vga_rect_plotter #(
        .X_SCREEN_PIXELS(XS), .Y_SCREEN_PIXELS(YS),
        .XW(XW), .YW(YW), .CW(CW), .SW(SW)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_x(input int x);
        bus.iXY_Coord = XW'(x);
        bus.iLoadX    = 1'b1;
        tick();
        bus.iLoadX    = 1'b0;
    endtask

    task automatic start_plot(input int y, input int c, input int w, input int h);
        bus.iXY_Coord = XW'(y);
        bus.iColour   = CW'(c);
        bus.iWidth    = SW'(w);
        bus.iHeight   = SW'(h);
        bus.iPlotBox  = 1'b1;
        tick();
        bus.iPlotBox  = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick();
        tick();
        if (bus.oX !== 8'd0) begin bad++; $display("FAIL reset_oX got=%0d want=0", bus.oX); end
        total++;
        if (bus.oY !== 7'd0) begin bad++; $display("FAIL reset_oY got=%0d want=0", bus.oY); end
        total++;
        if (bus.oColour !== 3'd0) begin bad++; $display("FAIL reset_oColour got=%0d want=0", bus.oColour); end
        total++;
        if ({bus.oPlot, bus.oBusy, bus.oDone} !== 3'b000) begin
            bad++; $display("FAIL reset_flags got=%b want=000", {bus.oPlot, bus.oBusy, bus.oDone});
        end
        total++;
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_draw_basic();
        logic [XW-1:0] ex;
        logic [YW-1:0] ey;
        load_x(10);
        start_plot(20, 5, 4, 4);
        for (int i = 0; i < 16; i++) begin
            ex = XW'(10 + i % 4);
            ey = YW'(20 + i / 4);
            if ({bus.oPlot, bus.oBusy, bus.oDone, bus.oX, bus.oY, bus.oColour} !==
                {1'b1, 1'b1, 1'b0, ex, ey, 3'd5}) begin
                bad++;
                $display("FAIL draw_px%0d got plot=%b busy=%b done=%b x=%0d y=%0d c=%0d want x=%0d y=%0d c=5",
                         i, bus.oPlot, bus.oBusy, bus.oDone, bus.oX, bus.oY, bus.oColour, ex, ey);
            end
            total++;
            // A load attempt during the draw must not move the origin.
            if (i == 2) begin bus.iXY_Coord = 8'd99; bus.iLoadX = 1'b1; end
            if (i == 3) bus.iLoadX = 1'b0;
            tick();
        end
        if ({bus.oDone, bus.oPlot, bus.oBusy} !== 3'b100) begin
            bad++; $display("FAIL draw_done got=%b want=100", {bus.oDone, bus.oPlot, bus.oBusy});
        end
        total++;
        tick();
        if ({bus.oDone, bus.oPlot, bus.oBusy, bus.oX, bus.oY} !== {3'b000, 8'd10, 7'd20}) begin
            bad++; $display("FAIL draw_idle got flags=%b x=%0d y=%0d want flags=000 x=10 y=20",
                            {bus.oDone, bus.oPlot, bus.oBusy}, bus.oX, bus.oY);
        end
        total++;
    endtask

    task automatic test_clip();
        int            xs;
        int            ys;
        logic          ep;
        load_x(158);
        start_plot(118, 2, 4, 3);
        for (int i = 0; i < 12; i++) begin
            xs = 158 + i % 4;
            ys = 118 + i / 4;
            ep = (xs < XS) && (ys < YS);
            if ({bus.oPlot, bus.oBusy, bus.oX, bus.oY} !== {ep, 1'b1, XW'(xs), YW'(ys)}) begin
                bad++;
                $display("FAIL clip_px%0d got plot=%b busy=%b x=%0d y=%0d want plot=%b x=%0d y=%0d",
                         i, bus.oPlot, bus.oBusy, bus.oX, bus.oY, ep, xs, ys);
            end
            total++;
            tick();
        end
        if ({bus.oDone, bus.oPlot, bus.oBusy} !== 3'b100) begin
            bad++; $display("FAIL clip_done got=%b want=100", {bus.oDone, bus.oPlot, bus.oBusy});
        end
        total++;
        tick();
    endtask

    task automatic test_zero_size();
        load_x(5);
        start_plot(9, 1, 0, 7);
        if ({bus.oDone, bus.oPlot, bus.oBusy} !== 3'b100) begin
            bad++; $display("FAIL zero_w got=%b want=100", {bus.oDone, bus.oPlot, bus.oBusy});
        end
        total++;
        tick();
        if ({bus.oDone, bus.oPlot, bus.oBusy} !== 3'b000) begin
            bad++; $display("FAIL zero_w_idle got=%b want=000", {bus.oDone, bus.oPlot, bus.oBusy});
        end
        total++;
        start_plot(9, 1, 3, 0);
        if ({bus.oDone, bus.oPlot, bus.oBusy} !== 3'b100) begin
            bad++; $display("FAIL zero_h got=%b want=100", {bus.oDone, bus.oPlot, bus.oBusy});
        end
        total++;
        tick();
    endtask

    task automatic test_clear_priority();
        bus.iXY_Coord = 8'd50;
        bus.iColour   = 3'd7;
        bus.iWidth    = 5'd2;
        bus.iHeight   = 5'd2;
        bus.iPlotBox  = 1'b1;
        bus.iBlack    = 1'b1;
        tick();
        bus.iBlack    = 1'b0;
        for (int i = 0; i < XS * YS; i++) begin
            if ({bus.oPlot, bus.oBusy, bus.oColour, bus.oX, bus.oY} !==
                {1'b1, 1'b1, 3'd0, XW'(i % XS), YW'(i / XS)}) begin
                bad++;
                $display("FAIL clear_px%0d got plot=%b busy=%b c=%0d x=%0d y=%0d want c=0 x=%0d y=%0d",
                         i, bus.oPlot, bus.oBusy, bus.oColour, bus.oX, bus.oY, i % XS, i / XS);
            end
            total++;
            tick();
        end
        if ({bus.oDone, bus.oPlot, bus.oBusy} !== 3'b100) begin
            bad++; $display("FAIL clear_done got=%b want=100", {bus.oDone, bus.oPlot, bus.oBusy});
        end
        total++;
        for (int i = 0; i < 4; i++) begin
            tick();
            if ({bus.oDone, bus.oPlot, bus.oBusy} !== 3'b000) begin
                bad++; $display("FAIL held_plot_idle%0d got=%b want=000", i, {bus.oDone, bus.oPlot, bus.oBusy});
            end
            total++;
        end
        bus.iPlotBox = 1'b0;
        tick();
        start_plot(30, 6, 2, 1);
        for (int i = 0; i < 2; i++) begin
            if ({bus.oPlot, bus.oColour, bus.oX, bus.oY} !== {1'b1, 3'd6, XW'(i), 7'd30}) begin
                bad++;
                $display("FAIL fresh_px%0d got plot=%b c=%0d x=%0d y=%0d want plot=1 c=6 x=%0d y=30",
                         i, bus.oPlot, bus.oColour, bus.oX, bus.oY, i);
            end
            total++;
            tick();
        end
        if (bus.oDone !== 1'b1) begin bad++; $display("FAIL fresh_done got=%b want=1", bus.oDone); end
        total++;
        tick();
    endtask

    task automatic test_reset_mid_draw();
        load_x(40);
        start_plot(60, 3, 4, 4);
        for (int i = 0; i < 5; i++) tick();
        if ({bus.oPlot, bus.oX, bus.oY} !== {1'b1, 8'd41, 7'd61}) begin
            bad++; $display("FAIL mid_px5 got plot=%b x=%0d y=%0d want plot=1 x=41 y=61",
                            bus.oPlot, bus.oX, bus.oY);
        end
        total++;
        resetn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if ({bus.oPlot, bus.oBusy, bus.oDone, bus.oX, bus.oY, bus.oColour} !== {3'b000, 8'd0, 7'd0, 3'd0}) begin
                bad++;
                $display("FAIL mid_reset%0d got plot=%b busy=%b done=%b x=%0d y=%0d c=%0d want all 0",
                         i, bus.oPlot, bus.oBusy, bus.oDone, bus.oX, bus.oY, bus.oColour);
            end
            total++;
        end
        resetn = 1'b1;
        tick();
        start_plot(60, 3, 2, 1);
        for (int i = 0; i < 2; i++) begin
            if ({bus.oPlot, bus.oX, bus.oY} !== {1'b1, XW'(i), 7'd60}) begin
                bad++; $display("FAIL post_reset_px%0d got plot=%b x=%0d y=%0d want plot=1 x=%0d y=60",
                                i, bus.oPlot, bus.oX, bus.oY, i);
            end
            total++;
            tick();
        end
        if (bus.oDone !== 1'b1) begin bad++; $display("FAIL post_reset_done got=%b want=1", bus.oDone); end
        total++;
        tick();
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        resetn        = 1'b0;
        bus.iXY_Coord = '0;
        bus.iLoadX    = 1'b0;
        bus.iPlotBox  = 1'b0;
        bus.iBlack    = 1'b0;
        bus.iColour   = '0;
        bus.iWidth    = '0;
        bus.iHeight   = '0;

        test_reset();
        test_draw_basic();
        test_clip();
        test_zero_size();
        test_clear_priority();
        test_reset_mid_draw();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_rect_plotter.md
Name: vga_rect_plotter

Overview:
- Parametrised successor to the fixed 4x4 box plotter in the lab VGA path.
- Draws a filled rectangle of runtime-selectable width/height at a loaded (x,y) origin in a chosen colour, or clears the whole screen to black.
- Emits one pixel per clock on oX/oY/oColour/oPlot toward the VGA adapter.
- Clips pixels that fall outside the screen; reports busy/done status to the top level.

Parameters:
- X_SCREEN_PIXELS, 160, screen width in pixels.
- Y_SCREEN_PIXELS, 120, screen height in pixels.
- XW, 8, x coordinate width; must satisfy 2^XW >= X_SCREEN_PIXELS.
- YW, 7, y coordinate width; must satisfy 2^YW >= Y_SCREEN_PIXELS.
- CW, 3, colour width.
- SW, 5, width of the size inputs; maximum rectangle side is 2^SW-1.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- iXY_Coord  in  XW  shared coordinate bus. Full width is loaded as x; low YW bits are loaded as y.
- iLoadX  in  1  rising edge loads x.
- iPlotBox  in  1  rising edge loads y, colour and size, then starts the draw.
- iBlack  in  1  rising edge starts a full-screen clear.
- iColour  in  CW  rectangle colour.
- iWidth  in  SW  rectangle width in pixels.
- iHeight  in  SW  rectangle height in pixels.
- oX  out  XW  pixel x.
- oY  out  YW  pixel y.
- oColour  out  CW  pixel colour.
- oPlot  out  1  pixel write enable.
- oBusy  out  1  high while in DRAW or CLEAR.
- oDone  out  1  one-cycle pulse when a draw or clear completes.

Behaviour:
- Edge detection:
  - iLoadX, iPlotBox and iBlack are each registered every cycle.
  - An edge is input high while the registered copy is low.
  - The registered copies track the inputs in every state, so a level held through a busy period never retriggers.
- Reset: while resetn is low at a clock edge:
  - state <= IDLE.
  - x_reg, y_reg, col_reg, w_reg, h_reg, xc, yc and all edge registers <= 0.
  - Outputs then read oX=0, oY=0, oColour=0, oPlot=0, oBusy=0, oDone=0.
  - Reset aborts any draw or clear immediately; no further oPlot is issued.
- States: IDLE, DRAW, CLEAR, DONE.
- IDLE, per-cycle edge handling. Priority is iBlack > iPlotBox > iLoadX; only the highest-priority edge in a cycle acts.
  - iLoadX edge: x_reg <= iXY_Coord.
  - iPlotBox edge:
    - y_reg <= iXY_Coord[YW-1:0], col_reg <= iColour, w_reg <= iWidth, h_reg <= iHeight; xc, yc <= 0.
    - If iWidth==0 or iHeight==0, go to DONE; otherwise go to DRAW.
  - iBlack edge:
    - x_reg, y_reg, col_reg <= 0; w_reg <= X_SCREEN_PIXELS; h_reg <= Y_SCREEN_PIXELS; xc, yc <= 0.
    - Go to CLEAR. w_reg and h_reg are sized to hold the screen dimensions.
- DRAW / CLEAR pixel scan:
  - One pixel per cycle in raster order, x fastest: xc counts 0..w_reg-1.
  - When xc wraps to 0, yc increments.
  - After the pixel (w_reg-1, h_reg-1), go to DONE.
  - Total scan time is exactly w_reg*h_reg cycles.
- Pixel outputs (combinational from state and registers):
  - oX = low XW bits of (x_reg + xc); oY = low YW bits of (y_reg + yc); oColour = col_reg.
  - Sums are formed at XW+1 and YW+1 bits.
  - oPlot = 1 only in DRAW/CLEAR when the full-width sum x < X_SCREEN_PIXELS and y < Y_SCREEN_PIXELS.
  - Clipped pixels still consume their cycle, with oPlot=0.
- Latency: an edge sampled at clock edge T gives the first pixel valid in the cycle following T.
- While busy:
  - All edges and iXY_Coord are ignored, and x_reg holds.
  - iColour/iWidth/iHeight changes have no effect, since they are latched at start.
- DONE: oDone=1 for exactly one cycle, oPlot=0, then return to IDLE. A new edge is accepted in the cycle after DONE.
- In IDLE: oPlot=0 and oBusy=0; oX/oY/oColour still reflect x_reg+0, y_reg+0, col_reg.

Test Plan:
- Reset, iLoadX edge with coord 10, iPlotBox edge with coord 20, iColour=5, w=4, h=4 -> 16 consecutive oPlot cycles covering (10..13, 20..23) in x-fastest order, oColour=5, oBusy high for those 16 cycles, oDone pulses 1 cycle after the last pixel.
- Origin (158,118), w=4, h=3, colour 2 -> 12 scan cycles; oPlot high only at (158,118), (159,118), (158,119), (159,119); oDone after cycle 12.
- iBlack edge -> 19200 oPlot cycles with oColour=0, sweeping (0,0)..(159,119), then a single oDone pulse.
- iWidth=0, h=7 -> no oPlot, oBusy stays 0, oDone pulses in the cycle after the edge; iHeight=0 behaves the same.
- iBlack and iPlotBox rise in the same cycle -> clear executes. iPlotBox held high through and after the clear -> no second draw. A later fresh iPlotBox edge -> draw runs.
- resetn low on the 6th pixel of a 4x4 draw -> oPlot=0 from that cycle on, oX=oY=0, state IDLE; the next draw starts from xc=yc=0.
